// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer for the data memory.
// Ports: req/we/addr/wdata/funct3 per port in, ack/err/rdata per port
// out, busy out, m_* drive the async-read/sync-write memory.
module mem_arbiter #(
    parameter int DEPTH_WORDS = 24576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [2:0]  funct3_0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [2:0]  funct3_1,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        busy,
    output logic [31:0] m_r_addr,
    output logic [31:0] m_w_addr,
    output logic [31:0] m_w_data,
    output logic [2:0]  m_funct3,
    output logic        m_mem_write,
    input  logic [31:0] m_r_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH_WORDS);

    logic [1:0]  state;
    logic        prio;
    logic        id_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_f3;

    function automatic logic chk_err(
        input logic        we,
        input logic [31:0] a,
        input logic [2:0]  f3
    );
        logic bad_f3;
        logic bad_st;
        logic bad_h;
        logic bad_w;
        logic bad_rng;
        bad_f3  = !(f3 inside {3'b000, 3'b001, 3'b010,
                               3'b100, 3'b101});
        bad_st  = we & f3[2];
        // a halfword only faults when it would span two words
        bad_h   = (f3[1:0] == 2'b01) & (a[1:0] == 2'b11);
        bad_w   = (f3[1:0] == 2'b10) & (a[1:0] != 2'b00);
        bad_rng = (a >= ADDR_LIM);
        return bad_f3 | bad_st | bad_h | bad_w | bad_rng;
    endfunction

    // single requester wins outright; on contention prio decides
    always_comb begin
        win = 1'b0;
        if (req0 && req1) win = prio;
        else if (req1)    win = 1'b1;
    end

    always_comb begin
        sel_we    = win ? we1      : we0;
        sel_addr  = win ? addr1    : addr0;
        sel_wdata = win ? wdata1   : wdata0;
        sel_f3    = win ? funct3_1 : funct3_0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            prio    <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= 32'h0;
            rdata1  <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        id_q    <= win;
                        prio    <= ~win;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        f3_q    <= sel_f3;
                        err_q   <= chk_err(sel_we, sel_addr, sel_f3);
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // rejected access returns zero; clean store keeps rdata
                    if (err_q || !we_q) begin
                        if (id_q) rdata1 <= err_q ? 32'h0 : m_r_data;
                        else      rdata0 <= err_q ? 32'h0 : m_r_data;
                    end
                    if (id_q) begin
                        ack1 <= 1'b1;
                        err1 <= err_q;
                    end else begin
                        ack0 <= 1'b1;
                        err0 <= err_q;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign m_r_addr = addr_q;
    assign m_w_addr = addr_q;
    assign m_w_data = wdata_q;
    assign m_funct3 = f3_q;

    // combinational so a reset in ACCESS blocks the write on that edge
    assign m_mem_write = (state == S_ACCESS) & we_q & ~err_q & ~rst;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory (24576 words, async read, sync write, `funct3`-sized accesses). It shares the memory between port 0 (CPU load/store unit) and port 1 (program loader / debug DMA) using round-robin arbitration and a req/ack handshake. It checks every access for alignment, size legality and address range before the memory is touched. Each transaction takes one memory access cycle, and read data is returned in a register.

## Interface
- `DEPTH_WORDS`, 24576, memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1 (0x00000–0x17FFF).
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: request from port 0 / 1; held high with fields stable until ack.
- `we0` / `we1` in 1: 1 = store, 0 = load.
- `addr0` / `addr1` in 32: byte address.
- `wdata0` / `wdata1` in 32: store data, with the value in the low bits.
- `funct3_0` / `funct3_1` in 3: RISC-V size code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `err0` / `err1` out 1: valid with ack; 1 = access rejected.
- `rdata0` / `rdata1` out 32: registered load result, valid with ack.
- `busy` out 1: high when state != IDLE.
- `m_r_addr`, `m_w_addr` out 32: memory addresses; both carry the latched address.
- `m_w_data` out 32: latched store data.
- `m_funct3` out 3: latched size code.
- `m_mem_write` out 1: memory write enable.
- `m_r_data` in 32: memory combinational read data.

## Operation
- States are IDLE, ACCESS and DONE. Reset forces IDLE.
- **IDLE**
  - If any req is high, pick a winner. Latch `we`, `addr`, `wdata`, `funct3` and the port id, compute `err_q`, and go to ACCESS.
  - If no req is high, stay in IDLE.
- **ACCESS**, one cycle
  - Memory outputs carry the latched fields.
  - `m_mem_write` = ACCESS & we_q & ~err_q & ~rst. This is combinational, so a reset or an error suppresses the write on that edge.
  - At the end of the cycle: if it is a load and err_q=0, capture `m_r_data` into the winner's `rdata`. If err_q=1, load 0 into the winner's `rdata`. For a store, `rdata` is left unchanged.
  - Next state is DONE.
- **DONE**, one cycle
  - The winner's `ack` = 1 and `err` = err_q. The other port's `ack` = 0.
  - Req inputs are ignored in this state. The requester drops req or presents a new request on this edge.
  - Next state is IDLE.
- **Arbitration** uses a round-robin pointer `prio`, which resets to 0.
  - When only one port requests, that port wins.
  - When both request, port `prio` wins.
  - After each grant, `prio` is set to the loser's id.
- **Error conditions** (err_q=1):
  - funct3 is not in {000, 001, 010, 100, 101}.
  - A store with funct3 100 or 101.
  - Halfword with addr[1:0] == 11.
  - Word with addr[1:0] != 00.
  - addr >= 4*DEPTH_WORDS.
- When not in ACCESS, memory outputs keep their last latched values and `m_mem_write` = 0.
- Reset values:
  - state = IDLE, prio = 0, latched fields 0.
  - ack0/1 = 0, err0/1 = 0, rdata0/1 = 0, busy = 0, `m_mem_write` = 0.

## Timing
- Cycle 0: req is sampled high in IDLE.
- Cycle 1: ACCESS. Store commits at the end of this cycle; load data is captured.
- Cycle 2: DONE, with ack high.
- Earliest next grant is sampled in cycle 3, so each transaction occupies 3 cycles. The maximum rate is one transaction per 3 cycles.
- Worst-case wait when both ports saturate: one foreign transaction (3 cycles).
- A request that arrives during ACCESS or DONE waits for the next IDLE. It is never dropped while req is held.
- Reset during ACCESS: no write, no ack. State is IDLE in the next cycle, and the requester must re-issue.
- Reset during DONE: ack is suppressed from the next cycle, because the ack and err registers are reset.
- A req that is deasserted before ack is a protocol violation. Once latched, the transaction completes anyway.

## Test plan
- Store then load:
  - Port 0 issues sw (010) addr 0x10 wdata 0xDEADBEEF. Expect `m_mem_write` high for exactly 1 cycle, `m_w_addr` = 0x10, ack0 two cycles after the req sample, err0 = 0.
  - Port 0 then issues lw at 0x10. Expect rdata0 = 0xDEADBEEF.
- Byte sign handling:
  - sb 0x80 to 0x21.
  - lb at 0x21 returns 0xFFFFFF80 and lbu at 0x21 returns 0x00000080.
- Round-robin:
  - req0 and req1 both held continuously after reset, 4 loads.
  - Expected grant order is 0, 1, 0, 1. Acks appear on cycles 2, 5, 8, 11.
- Misalignment:
  - lw at 0x13 → ack0 with err0 = 1, rdata0 = 0, and no `m_mem_write`.
  - sh at 0x03 → err.
  - sh at 0x02 → ok.
- Range and illegal codes:
  - sw at 0x18000 → err, no write.
  - sw at 0x17FFC → ok.
  - funct3 011 → err.
  - Store with funct3 100 → err.
- Reset mid-access:
  - Assert rst during the ACCESS cycle of sw 0x55AA55AA to 0x40.
  - Expect no write (a later lw at 0x40 returns the old value), no ack, busy = 0 next cycle, prio = 0.
